multi_cycle_ctrl: RTL and testbench

Multi-cycle main control FSM for the MIPS-subset core. It sequences a shared datapath (one ALU, one unified instruction/data memory, regfile, IR, ALUOut register) across FETCH/DECODE/EXECUTE/MEM/WB steps. It supports R-type (0x00), LW (0x23), SW (0x2B), BEQ (0x04) and J (0x02). It also handles a variable-latency memory handshake with a timeout watchdog, and counts retired instructions.

---
 rtl/multi_cycle_ctrl_if.sv | 25 ++
 rtl/multi_cycle_ctrl.sv | 237 +++++++++++++++++++++++
 tb/tb_multi_cycle_ctrl.sv | 211 +++++++++++++++++++++
 3 files changed

// File: rtl/multi_cycle_ctrl_if.sv
// Memory bus between the multi-cycle controller and the unified memory.
//   mem_req   : access request, held until the cycle mem_ready is seen
//   mem_we    : write strobe, valid with mem_req
//   iord      : address select, 0=PC, 1=ALUOut
//   mem_ready : memory completes the current access this cycle
interface multi_cycle_ctrl_if;
  logic mem_req;
  logic mem_we;
  logic iord;
  logic mem_ready;

  modport master (
    output mem_req,
    output mem_we,
    output iord,
    input  mem_ready
  );

  modport slave (
    input  mem_req,
    input  mem_we,
    input  iord,
    output mem_ready
  );
endinterface

// File: rtl/multi_cycle_ctrl.sv
// Multi-cycle main control FSM for the MIPS-subset core.
// Sequences the shared datapath through FETCH/DECODE/EXECUTE/MEM/WB,
// supervises variable-latency memory accesses with a timeout watchdog
// and counts retired instructions.
// Ports:
//   clk, rst_n        : clock, asynchronous active-low reset
//   mem               : memory bus (master side)
//   instrn_opcode     : IR opcode field, valid from DECODE onward
//   zero_out          : ALU zero flag (branch decision)
//   ir_write..mem_to_reg : datapath enables and selects, decoded from state
//   state             : current FSM state (debug)
//   err               : sticky error code, 01=illegal opcode, 10=mem timeout
//   retired           : retired instruction count, wraps
module multi_cycle_ctrl #(
  parameter int unsigned TIMEOUT = 16,
  parameter int unsigned CNT_W   = 32
) (
  input  logic                 clk,
  input  logic                 rst_n,
  multi_cycle_ctrl_if.master   mem,
  input  logic [5:0]           instrn_opcode,
  input  logic                 zero_out,
  output logic                 ir_write,
  output logic                 pc_write,
  output logic [1:0]           pc_src,
  output logic                 alu_src_a,
  output logic [1:0]           alu_src_b,
  output logic [1:0]           alu_op,
  output logic                 reg_write,
  output logic                 reg_dst,
  output logic                 mem_to_reg,
  output logic [3:0]           state,
  output logic [1:0]           err,
  output logic [CNT_W-1:0]     retired
);

  localparam int unsigned WAIT_W = 8;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;

  localparam logic [1:0] ERR_NONE    = 2'b00;
  localparam logic [1:0] ERR_ILLEGAL = 2'b01;
  localparam logic [1:0] ERR_TIMEOUT = 2'b10;

  typedef enum logic [3:0] {
    S_IDLE      = 4'd0,
    S_FETCH     = 4'd1,
    S_DECODE    = 4'd2,
    S_MEM_ADDR  = 4'd3,
    S_MEM_READ  = 4'd4,
    S_MEM_WB    = 4'd5,
    S_MEM_WRITE = 4'd6,
    S_EXEC_R    = 4'd7,
    S_R_WB      = 4'd8,
    S_BRANCH    = 4'd9,
    S_JUMP      = 4'd10,
    S_ERROR     = 4'd11
  } state_e;

  state_e              state_q, state_d;
  logic [1:0]          err_q, err_d;
  logic [CNT_W-1:0]    retired_q;
  logic [WAIT_W-1:0]   wait_cnt;
  logic                wait_state_c;
  logic                timeout_c;
  logic                retire_c;

  // Watchdog fires on the last allowed idle cycle; a ready in that cycle wins.
  assign wait_state_c = (state_q == S_FETCH) || (state_q == S_MEM_READ) ||
                        (state_q == S_MEM_WRITE);
  assign timeout_c    = wait_state_c && !mem.mem_ready &&
                        (wait_cnt == WAIT_W'(TIMEOUT - 1));

  // Next-state and Moore decode; memory-completion enables gated by mem_ready.
  always_comb begin
    state_d      = state_q;
    err_d        = err_q;
    retire_c     = 1'b0;
    mem.mem_req  = 1'b0;
    mem.mem_we   = 1'b0;
    mem.iord     = 1'b0;
    ir_write     = 1'b0;
    pc_write     = 1'b0;
    pc_src       = 2'b00;
    alu_src_a    = 1'b0;
    alu_src_b    = 2'b00;
    alu_op       = 2'b00;
    reg_write    = 1'b0;
    reg_dst      = 1'b0;
    mem_to_reg   = 1'b0;

    case (state_q)
      S_IDLE: begin
        state_d = S_FETCH;
      end

      // PC+4 computed while the instruction is read.
      S_FETCH: begin
        mem.mem_req = 1'b1;
        alu_src_b   = 2'b01;
        if (mem.mem_ready) begin
          ir_write = 1'b1;
          pc_write = 1'b1;
          state_d  = S_DECODE;
        end else if (timeout_c) begin
          err_d   = ERR_TIMEOUT;
          state_d = S_ERROR;
        end
      end

      // Branch target precomputed into ALUOut.
      S_DECODE: begin
        alu_src_b = 2'b11;
        case (instrn_opcode)
          OP_LW, OP_SW: state_d = S_MEM_ADDR;
          OP_RTYPE:     state_d = S_EXEC_R;
          OP_BEQ:       state_d = S_BRANCH;
          OP_J:         state_d = S_JUMP;
          default: begin
            err_d   = ERR_ILLEGAL;
            state_d = S_ERROR;
          end
        endcase
      end

      S_MEM_ADDR: begin
        alu_src_a = 1'b1;
        alu_src_b = 2'b10;
        state_d   = (instrn_opcode == OP_LW) ? S_MEM_READ : S_MEM_WRITE;
      end

      S_MEM_READ: begin
        mem.mem_req = 1'b1;
        mem.iord    = 1'b1;
        if (mem.mem_ready) begin
          state_d = S_MEM_WB;
        end else if (timeout_c) begin
          err_d   = ERR_TIMEOUT;
          state_d = S_ERROR;
        end
      end

      S_MEM_WB: begin
        reg_write  = 1'b1;
        mem_to_reg = 1'b1;
        retire_c   = 1'b1;
        state_d    = S_FETCH;
      end

      S_MEM_WRITE: begin
        mem.mem_req = 1'b1;
        mem.iord    = 1'b1;
        mem.mem_we  = 1'b1;
        if (mem.mem_ready) begin
          retire_c = 1'b1;
          state_d  = S_FETCH;
        end else if (timeout_c) begin
          err_d   = ERR_TIMEOUT;
          state_d = S_ERROR;
        end
      end

      S_EXEC_R: begin
        alu_src_a = 1'b1;
        alu_op    = 2'b10;
        state_d   = S_R_WB;
      end

      S_R_WB: begin
        reg_write = 1'b1;
        reg_dst   = 1'b1;
        retire_c  = 1'b1;
        state_d   = S_FETCH;
      end

      // Compare A-B; PC takes ALUOut only when equal. Retires either way.
      S_BRANCH: begin
        alu_src_a = 1'b1;
        alu_op    = 2'b01;
        pc_src    = 2'b01;
        pc_write  = zero_out;
        retire_c  = 1'b1;
        state_d   = S_FETCH;
      end

      S_JUMP: begin
        pc_write = 1'b1;
        pc_src   = 2'b10;
        retire_c = 1'b1;
        state_d  = S_FETCH;
      end

      S_ERROR: begin
        state_d = S_ERROR;
      end

      default: begin
        state_d = S_ERROR;
      end
    endcase
  end

  // State, sticky error and retired counter.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= S_IDLE;
      err_q     <= ERR_NONE;
      retired_q <= '0;
    end else begin
      state_q <= state_d;
      err_q   <= err_d;
      if (retire_c) begin
        retired_q <= retired_q + CNT_W'(1);
      end
    end
  end

  // Wait counter: cleared on every state change, counts idle memory cycles.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wait_cnt <= '0;
    end else if (state_d != state_q) begin
      wait_cnt <= '0;
    end else if (wait_state_c && !mem.mem_ready) begin
      wait_cnt <= wait_cnt + WAIT_W'(1);
    end
  end

  assign state   = state_q;
  assign err     = err_q;
  assign retired = retired_q;

endmodule

// File: tb/tb_multi_cycle_ctrl.sv
// Scoreboard bench for multi_cycle_ctrl: each stimulus cycle pushes the
// expected observation; a negedge monitor pops and compares.
module tb_multi_cycle_ctrl;

  logic        clk;
  logic        rst_n;
  logic [5:0]  instrn_opcode;
  logic        zero_out;
  logic        ir_write, pc_write, alu_src_a, reg_write, reg_dst, mem_to_reg;
  logic [1:0]  pc_src, alu_src_b, alu_op, err;
  logic [3:0]  state;
  logic [31:0] retired;

  multi_cycle_ctrl_if mem_bus ();

  multi_cycle_ctrl #(.TIMEOUT(16), .CNT_W(32)) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .mem           (mem_bus),
    .instrn_opcode (instrn_opcode),
    .zero_out      (zero_out),
    .ir_write      (ir_write),
    .pc_write      (pc_write),
    .pc_src        (pc_src),
    .alu_src_a     (alu_src_a),
    .alu_src_b     (alu_src_b),
    .alu_op        (alu_op),
    .reg_write     (reg_write),
    .reg_dst       (reg_dst),
    .mem_to_reg    (mem_to_reg),
    .state         (state),
    .err           (err),
    .retired       (retired)
  );

  typedef struct packed {
    logic [3:0]  st;
    logic [1:0]  er;
    logic [31:0] ret;
    logic        mem_req;
    logic        mem_we;
    logic        iord;
    logic        ir_wr;
    logic        pc_wr;
    logic [1:0]  pc_src;
    logic        src_a;
    logic [1:0]  src_b;
    logic [1:0]  op;
    logic        rw;
    logic        rdst;
    logic        m2r;
  } obs_t;

  obs_t exp_q[$];
  int   n_tests = 0;
  int   n_fail  = 0;
  int   n_step  = 0;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout, required completion");
    $fatal(1);
  end

  // Control word written out from the per-state table of the datasheet.
  function automatic obs_t expect_obs(input logic [3:0] st, input logic mr,
                                      input logic zo, input logic [1:0] er,
                                      input logic [31:0] ret);
    obs_t o;
    o = '0;
    o.st  = st;
    o.er  = er;
    o.ret = ret;
    case (st)
      4'd1:  begin o.mem_req = 1'b1; o.src_b = 2'b01; o.ir_wr = mr; o.pc_wr = mr; end
      4'd2:  begin o.src_b = 2'b11; end
      4'd3:  begin o.src_a = 1'b1; o.src_b = 2'b10; end
      4'd4:  begin o.mem_req = 1'b1; o.iord = 1'b1; end
      4'd5:  begin o.rw = 1'b1; o.m2r = 1'b1; end
      4'd6:  begin o.mem_req = 1'b1; o.iord = 1'b1; o.mem_we = 1'b1; end
      4'd7:  begin o.src_a = 1'b1; o.op = 2'b10; end
      4'd8:  begin o.rw = 1'b1; o.rdst = 1'b1; end
      4'd9:  begin o.src_a = 1'b1; o.op = 2'b01; o.pc_src = 2'b01; o.pc_wr = zo; end
      4'd10: begin o.pc_wr = 1'b1; o.pc_src = 2'b10; end
      default: ;
    endcase
    return o;
  endfunction

  // One clock of stimulus plus the expected observation for that cycle.
  task automatic step(input logic rn, input logic mr, input logic zo,
                      input logic [5:0] op, input logic [3:0] st,
                      input logic [1:0] er, input logic [31:0] ret);
    @(posedge clk);
    #1;
    rst_n             = rn;
    mem_bus.mem_ready = mr;
    zero_out          = zo;
    instrn_opcode     = op;
    exp_q.push_back(expect_obs(st, mr, zo, er, ret));
  endtask

  // Monitor: compare the full observation mid-cycle.
  always @(negedge clk) begin
    obs_t act, exp_o;
    if (exp_q.size() > 0) begin
      exp_o = exp_q.pop_front();
      act = '{st: state, er: err, ret: retired, mem_req: mem_bus.mem_req,
              mem_we: mem_bus.mem_we, iord: mem_bus.iord, ir_wr: ir_write,
              pc_wr: pc_write, pc_src: pc_src, src_a: alu_src_a,
              src_b: alu_src_b, op: alu_op, rw: reg_write, rdst: reg_dst,
              m2r: mem_to_reg};
      n_tests++;
      if (act !== exp_o) begin
        n_fail++;
        $display("FAIL step%0d state: got st=%0d err=%0d ret=%0d ctrl=%h, required st=%0d err=%0d ret=%0d ctrl=%h",
                 n_step, act.st, act.er, act.ret, act[15:0],
                 exp_o.st, exp_o.er, exp_o.ret, exp_o[15:0]);
      end
      n_step++;
    end
  end

  initial begin
    rst_n             = 1'b0;
    mem_bus.mem_ready = 1'b0;
    zero_out          = 1'b0;
    instrn_opcode     = 6'h00;

    // Reset
    step(0, 1, 0, 6'h00, 0, 0, 0);
    step(0, 1, 0, 6'h00, 0, 0, 0);
    step(1, 1, 0, 6'h00, 0, 0, 0);

    // R-type, zero-wait: 1,2,7,8 then FETCH with retired=1
    step(1, 1, 0, 6'h00, 1, 0, 0);
    step(1, 1, 0, 6'h00, 2, 0, 0);
    step(1, 1, 0, 6'h00, 7, 0, 0);
    step(1, 1, 0, 6'h00, 8, 0, 0);

    // LW: FETCH waits 3, MEM_READ waits 2
    for (int i = 0; i < 3; i++) step(1, 0, 0, 6'h23, 1, 0, 1);
    step(1, 1, 0, 6'h23, 1, 0, 1);
    step(1, 1, 0, 6'h23, 2, 0, 1);
    step(1, 1, 0, 6'h23, 3, 0, 1);
    for (int i = 0; i < 2; i++) step(1, 0, 0, 6'h23, 4, 0, 1);
    step(1, 1, 0, 6'h23, 4, 0, 1);
    step(1, 1, 0, 6'h23, 5, 0, 1);

    // BEQ taken
    step(1, 1, 1, 6'h04, 1, 0, 2);
    step(1, 1, 1, 6'h04, 2, 0, 2);
    step(1, 1, 1, 6'h04, 9, 0, 2);
    // BEQ not taken
    step(1, 1, 0, 6'h04, 1, 0, 3);
    step(1, 1, 0, 6'h04, 2, 0, 3);
    step(1, 1, 0, 6'h04, 9, 0, 3);

    // SW then J
    step(1, 1, 0, 6'h2B, 1, 0, 4);
    step(1, 1, 0, 6'h2B, 2, 0, 4);
    step(1, 1, 0, 6'h2B, 3, 0, 4);
    step(1, 1, 0, 6'h2B, 6, 0, 4);
    step(1, 1, 0, 6'h02, 1, 0, 5);
    step(1, 1, 0, 6'h02, 2, 0, 5);
    step(1, 1, 0, 6'h02, 10, 0, 5);

    // Illegal opcode: terminal ERROR with err=01
    step(1, 1, 0, 6'h3F, 1, 0, 6);
    step(1, 1, 0, 6'h3F, 2, 0, 6);
    for (int i = 0; i < 20; i++) step(1, 1'(i % 2), 1'(i % 3 == 0), 6'h3F, 11, 1, 6);

    // Reset pulse clears state, err and retired
    step(0, 0, 0, 6'h00, 0, 0, 0);
    step(1, 0, 0, 6'h00, 0, 0, 0);

    // FETCH timeout after exactly 16 waiting cycles
    for (int i = 0; i < 16; i++) step(1, 0, 0, 6'h00, 1, 0, 0);
    for (int i = 0; i < 3; i++) step(1, 0, 0, 6'h00, 11, 2, 0);

    // Ready on the 16th cycle wins over the watchdog
    step(0, 0, 0, 6'h00, 0, 0, 0);
    step(1, 0, 0, 6'h00, 0, 0, 0);
    for (int i = 0; i < 15; i++) step(1, 0, 0, 6'h00, 1, 0, 0);
    step(1, 1, 0, 6'h00, 1, 0, 0);
    step(1, 1, 0, 6'h00, 2, 0, 0);
    step(1, 1, 0, 6'h00, 7, 0, 0);
    step(1, 1, 0, 6'h00, 8, 0, 0);
    step(1, 0, 0, 6'h00, 1, 0, 1);

    // Reset mid-access drops mem_req at once
    step(0, 0, 0, 6'h00, 0, 0, 0);

    @(negedge clk);
    #1;
    n_tests++;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL drain: got %0d pending expectations, required 0", exp_q.size());
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
